// File: rtl/serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_alu_sequencer
//  Purpose  : Bit-serial WIDTH-bit ALU. A word operation is accepted on a
//             start handshake, processed one bit per clock (LSB first) with
//             the carry held in a flop, and the collected word result and
//             flags are presented together with a one-cycle done pulse.
//  Ports    : clk, rst       - rising-edge clock, async active-high reset
//             start          - request, accepted only when idle
//             op[2:0]        - op[2] inverts b and is the bit-0 carry-in;
//                              op[1:0]: 00 AND, 01 OR, 10 sum, 11 less
//             a, b           - operands, sampled on an accepted start
//             busy           - high while bits are being processed
//             done           - one-cycle pulse, result fields valid
//             result         - word result
//             carry_out      - carry out of the MSB
//             overflow       - carry into MSB xor carry out of MSB
//             zero           - result == 0
//  Revision : 1.0 - initial release
// ============================================================================
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  // One-bit slice signals for the current bit
  logic             bb;
  logic             sum_bit;
  logic             cnext;
  logic             bit_res;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] patched;

  always_comb begin
    // Operands are shifted right each bit, so the current bit is always [0]
    bb      = b_q[0] ^ op_q[2];
    sum_bit = a_q[0] ^ bb ^ carry_q;
    cnext   = (a_q[0] & bb) | (a_q[0] & carry_q) | (bb & carry_q);

    case (op_q[1:0])
      2'b00:   bit_res = a_q[0] & bb;
      2'b01:   bit_res = a_q[0] | bb;
      2'b10:   bit_res = sum_bit;
      default: bit_res = 1'b0;
    endcase

    shifted = {bit_res, result_q[WIDTH-1:1]};

    // On the last bit the sum bit is the sign of a +/- b ("set"); for the
    // less op it becomes bit 0 of the result, and it is folded in here so
    // the patched value and zero flag are visible in the done cycle.
    patched = shifted;
    if (op_q[1:0] == 2'b11) begin
      patched[0] = sum_bit;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d         = a;
          b_d         = b;
          op_d        = op;
          carry_d     = op[2];
          cnt_d       = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          zero_d      = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = cnext;
        if (cnt_q == LAST) begin
          result_d    = patched;
          carry_out_d = cnext;
          overflow_d  = carry_q ^ cnext;
          zero_d      = (patched == '0);
          state_d     = DONE;
        end else begin
          result_d = shifted;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_alu_sequencer
//  Purpose  : Self-checking bench for serial_alu_sequencer. Expected word
//             results come from a word-level reference model and are queued
//             when an operation is issued, then popped when done pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry_out, overflow, zero;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  exp_t exp_q[$];

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Word-level reference: a full-width add plus a separate (W-1)-bit add to
  // obtain the carry into the MSB.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic [W-1:0] low;
    logic         cin;
    cin  = o[2];
    yy   = cin ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cin};
    low  = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + {{(W-1){1'b0}}, cin};
    e.co = full[W];
    e.ov = low[W-1] ^ full[W];
    case (o[1:0])
      2'b00:   e.res = x & yy;
      2'b01:   e.res = x | yy;
      2'b10:   e.res = full[W-1:0];
      default: e.res = {{(W-1){1'b0}}, full[W-1]};
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Issue one operation, wait for done, check latency, busy length, fields,
  // pulse width and output hold.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int   n;
    int   busy_cnt;
    exp_t e;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout op=%b: no done within %0d cycles", o, n);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (n !== W + 1) begin
      n_err++;
      $display("FAIL latency op=%b: got %0d required %0d", o, n, W + 1);
    end
    n_cmp++;
    if (busy_cnt !== W) begin
      n_err++;
      $display("FAIL busy_len op=%b: got %0d required %0d", o, busy_cnt, W);
    end
    n_cmp++;
    if ({result, carry_out, overflow, zero} !== e) begin
      n_err++;
      $display("FAIL result op=%b a=%h b=%h: got res=%h co=%b ov=%b z=%b required res=%h co=%b ov=%b z=%b",
               o, x, y, result, carry_out, overflow, zero, e.res, e.co, e.ov, e.z);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse op=%b: got done=%b busy=%b required 0 0", o, done, busy);
    end
    n_cmp++;
    if ({result, carry_out, overflow, zero} !== e) begin
      n_err++;
      $display("FAIL hold op=%b: got res=%h required %h", o, result, e.res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, carry_out, overflow, zero, result} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b co=%b ov=%b z=%b res=%h required all 0",
               busy, done, carry_out, overflow, zero, result);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_arith();
    run_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op(3'b110, 32'h0000_0005, 32'h0000_0005);
    run_op(3'b110, 32'h0000_0000, 32'h0000_0001);
  endtask

  task automatic test_less();
    run_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(3'b111, 32'h0000_0003, 32'h0000_0002);
    run_op(3'b111, 32'h8000_0000, 32'h0000_0001);
    run_op(3'b011, 32'hFFFF_FFF0, 32'h0000_0004);
  endtask

  task automatic test_logic();
    run_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
  endtask

  // Extra start pulses during RUN (bit 4, last bit) and in DONE are ignored.
  task automatic test_handshake();
    int   n;
    int   done_n;
    int   pulses;
    exp_t e;
    exp_q.push_back(model(3'b010, 32'h1234_5678, 32'h1111_1111));
    @(negedge clk);
    op = 3'b010; a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    done_n = 0;
    pulses = 0;
    for (n = 1; n < 80; n++) begin
      if (done) begin
        pulses++;
        if (done_n == 0) done_n = n;
      end
      start = (n == 5 || n == 32 || n == 33);
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL hs_done_count: got %0d pulses required 1", pulses);
    end
    n_cmp++;
    if (done_n !== W + 1) begin
      n_err++;
      $display("FAIL hs_latency: got %0d required %0d", done_n, W + 1);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (result !== e.res || carry_out !== e.co || overflow !== e.ov || zero !== e.z) begin
      n_err++;
      $display("FAIL hs_result: got res=%h co=%b ov=%b required res=%h co=%b ov=%b",
               result, carry_out, overflow, e.res, e.co, e.ov);
    end
  endtask

  // start held high: operations every WIDTH+2 cycles, new a each time.
  task automatic test_back_to_back();
    int   n;
    int   last_n;
    int   seen;
    exp_t e;
    @(negedge clk);
    op = 3'b010; a = 32'd100; b = 32'd7; start = 1'b1;
    exp_q.push_back(model(3'b010, 32'd100, 32'd7));
    seen = 0;
    last_n = 0;
    for (n = 1; n < 200 && seen < 3; n++) begin
      @(negedge clk);
      if (done) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== e.res) begin
          n_err++;
          $display("FAIL b2b_result[%0d]: got %h required %h", seen, result, e.res);
        end
        if (seen > 0) begin
          n_cmp++;
          if (n - last_n !== W + 2) begin
            n_err++;
            $display("FAIL b2b_spacing[%0d]: got %0d required %0d", seen, n - last_n, W + 2);
          end
        end
        last_n = n;
        seen++;
        if (seen < 3) begin
          a = a + 32'd1000;
          exp_q.push_back(model(3'b010, a, 32'd7));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (seen !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d required 3", seen);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    op = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, carry_out, overflow, zero, result} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b co=%b ov=%b z=%b res=%h required all 0",
               busy, done, carry_out, overflow, zero, result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL discarded_op: got %0d busy/done cycles required 0", pulses);
    end
    run_op(3'b010, 32'd2, 32'd3);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_less();
    test_logic();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_alu_sequencer.md
Name: serial_alu_sequencer

Overview:
- Bit-serial WIDTH-bit ALU that drives the one-bit ALU slice protocol from the word side.
- Accepts a word operation on a start handshake, then processes one bit per clock, LSB first.
- Carry is held in a flip-flop between bits.
- Collects result, set, carry and overflow into word outputs, then pulses done.
- Used as a small-area alternative to the parallel CLA datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- op  input  3  op[2]=binv (invert b, carry-in of bit 0), op[1:0]: 00 AND, 01 OR, 10 sum, 11 less
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle pulse; result fields valid
- result  output  WIDTH  word result
- carry_out  output  1  carry out of MSB
- overflow  output  1  signed overflow of MSB sum (carry into MSB XOR carry out of MSB)
- zero  output  1  result == 0

Behaviour:
- Reset (async, any state):
  - State returns to IDLE.
  - busy, done, result, carry_out, overflow and zero all go to 0.
  - Internal operand/op/bit-counter registers are cleared.
  - Any in-flight operation is discarded and never completes.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture a, b, op; carry register <= op[2]; counter <= 0; go to RUN.
  - start=0: stay.
- RUN, one bit i = counter per cycle:
  - bb = b[i] ^ op[2]
  - s = a[i] ^ bb ^ c
  - cnext = majority(a[i], bb, c)
  - Bit result by op[1:0]: 00 a[i]&bb; 01 a[i]|bb; 10 s; 11 0 (less input is 0 for every bit; bit 0 is patched in DONE).
  - Bit result shifts into result from the MSB side (result <= {bit, result[WIDTH-1:1]}); carry register <= cnext; counter increments.
  - At i = WIDTH-1:
    - set <= s (sign of a ± b)
    - carry_out <= cnext
    - overflow <= c ^ cnext
    - go to DONE.
- RUN duration is exactly WIDTH cycles; counter is $clog2(WIDTH) bits wide and never wraps in use.
- DONE (one cycle):
  - done=1, busy=0.
  - If op[1:0]=11, result[0] <= set; all other bits stay 0.
  - zero is computed on the final result value.
  - Return to IDLE.
  - The patch and zero must be visible in the same cycle done is high: register them on RUN→DONE, using the set value computed from the last bit.
- Latency: start accepted on edge N; done high during cycle N+WIDTH+1; busy high during cycles N+1 … N+WIDTH.
- Output hold: result, carry_out, overflow and zero hold their values after done until the next accepted start, then clear at acceptance.
- Flags on non-sum ops: carry_out and overflow are computed identically for every op, because the adder always runs. Consumers ignore them for AND/OR.
- Less semantics: raw sign of a - b, with no overflow correction (matches the slice set output).
- start while busy or in DONE is ignored, not queued. start held high through DONE is accepted on the next IDLE cycle.
- All 8 op codes are legal and follow the rules above, e.g. 100 = a & ~b, 101 = a | ~b, 011 = sign(a + b).

Test Plan:
- ADD (op=010), a=0x7FFFFFFF, b=0x00000001:
  - Expect result=0x80000000, overflow=1, carry_out=0, zero=0.
  - done exactly 33 cycles after the start edge; busy high for 32 cycles.
- SUB (op=110), a=b=0x00000005:
  - Expect result=0, zero=1, carry_out=1, overflow=0.
  - Then a=0, b=1: result=0xFFFFFFFF, carry_out=0.
- LESS (op=111):
  - a=0xFFFFFFFF, b=0x00000001: result=0x00000001.
  - a=3, b=2: result=0, zero=1.
  - a=0x80000000, b=0x00000001: result=0 (overflow not corrected), overflow=1.
- AND/OR, a=0xF0F0F0F0, b=0xFF00FF00:
  - op=000: result=0xF000F000.
  - op=001: result=0xFFF0FFF0.
  - op=100: result=0x00F000F0.
- Handshake:
  - Pulse start again at cycles +5 and +32 of an ADD with different operands. The original result is unchanged and only one done pulse occurs.
  - start held high continuously yields back-to-back operations spaced WIDTH+2 cycles apart.
- Reset mid-operation:
  - Assert rst at RUN bit 10: all outputs 0 immediately (asynchronous), with no done pulse afterwards.
  - After release, a fresh ADD 2+3 returns 5 with correct latency.
